// File: rtl/alu32_pkg.sv
// rtl/alu32_pkg.sv - shared constants for the alu32 sequential divider
//
// Purpose: datapath width, divider FSM state encodings and the quotient
// value reported on a divide by zero.
// Ports: none (package).
package alu32_pkg;

  localparam int WIDTH = 32;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFFFFFF;

endpackage

// File: rtl/alu32_full_adder.sv
// rtl/alu32_full_adder.sv - one-bit full adder cell of the alu32 datapath
//
// Purpose: single ripple cell shared by the adder/subtractor and divider.
// Ports:
//   a, b  : operand bits
//   cin   : carry in
//   sum   : a ^ b ^ cin
//   cout  : carry out
module alu32_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/alu32_seq_divider_div_step.sv
// rtl/alu32_seq_divider_div_step.sv - one restoring-division trial subtract and select
//
// Purpose: shifts the next dividend bit into the partial remainder, subtracts
// the divisor magnitude (inverted subtrahend, carry-in 1) and keeps the
// difference when it is non-negative.
// Ports:
//   rem         : current partial remainder (always < divisor_mag)
//   dvd_bit     : next dividend bit, shifted in at the bottom
//   divisor_mag : divisor magnitude
//   rem_next    : partial remainder after this step
//   q_bit       : quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_next,
  output logic             q_bit
);

  logic [WIDTH-1:0] shifted_lo;
  logic [WIDTH-1:0] diff;
  logic [WIDTH:0]   carry;

  // The shifted remainder is WIDTH+1 bits; its top bit is rem[WIDTH-1].
  assign shifted_lo = {rem[WIDTH-2:0], dvd_bit};
  assign carry[0]   = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    alu32_full_adder u_fa (
      .a    (shifted_lo[i]),
      .b    (~divisor_mag[i]),
      .cin  (carry[i]),
      .sum  (diff[i]),
      .cout (carry[i+1])
    );
  end

  // Top cell of the 33-bit subtract: subtrahend bit is 0, inverted to 1, so
  // its carry out reduces to a | cin. Carry out set means no borrow (t >= 0).
  assign q_bit = rem[WIDTH-1] | carry[WIDTH];

  // A kept difference is below divisor_mag, so it always fits in WIDTH bits;
  // a rejected shift can only happen when the top bit was 0.
  assign rem_next = q_bit ? diff : shifted_lo;

endmodule

// File: rtl/alu32_seq_divider.sv
// rtl/alu32_seq_divider.sv - multi-cycle 32-bit signed/unsigned integer divider
//
// Purpose: restoring division, one quotient bit per clock, with sign fix-up
// (truncating division) and divide-by-zero short cut. Results held until the
// next accepted start.
// Ports:
//   clk, reset       : clock (rising edge), asynchronous active-high reset
//   start            : request, sampled only while idle
//   signed_op        : 1 = two's-complement divide, captured with start
//   dividend/divisor : operands, captured with start
//   busy             : operation in progress
//   done             : one-cycle pulse when results update
//   quotient/remainder/div_by_zero : registered results
module alu32_seq_divider #(
  parameter int WIDTH = alu32_pkg::WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  import alu32_pkg::*;

  logic [1:0]       state;
  logic [WIDTH-1:0] rem;      // partial remainder; 33rd bit exists only inside div_step
  logic [WIDTH-1:0] dvd;      // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] dmag;
  logic [CNT_W-1:0] cnt;
  logic             sign_q;
  logic             sign_r;
  logic             dz;

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  // Negative flags are already gated by signed_op, so the captured signs
  // alone decide the fix-up.
  assign neg_a = signed_op & dividend[WIDTH-1];
  assign neg_b = signed_op & divisor[WIDTH-1];
  assign mag_a = neg_a ? -dividend : dividend;
  assign mag_b = neg_b ? -divisor  : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem         (rem),
    .dvd_bit     (dvd[WIDTH-1]),
    .divisor_mag (dmag),
    .rem_next    (step_rem),
    .q_bit       (step_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rem         <= '0;
      dvd         <= '0;
      dmag        <= '0;
      cnt         <= '0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      dz          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_q <= neg_a ^ neg_b;
            sign_r <= neg_a;
            rem    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            if (divisor == '0) begin
              // Raw dividend is kept so FIX can return it unmodified.
              dz    <= 1'b1;
              dvd   <= dividend;
              dmag  <= '0;
              state <= FIX;
            end else begin
              dz    <= 1'b0;
              dvd   <= mag_a;
              dmag  <= mag_b;
              state <= RUN;
            end
          end
        end
        RUN: begin
          rem <= step_rem;
          dvd <= {dvd[WIDTH-2:0], step_q};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          if (dz) begin
            quotient    <= DIV_ZERO_Q;
            remainder   <= dvd;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= sign_q ? -dvd : dvd;
            remainder   <= sign_r ? -rem : rem;
            div_by_zero <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu32_seq_divider.sv
// tb/tb_alu32_seq_divider.sv - self-checking bench for alu32_seq_divider
module tb_alu32_seq_divider;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int   checks;
  int   errors;
  exp_t sb[$];

  alu32_seq_divider dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_op   (signed_op),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [31:0] q, input logic [31:0] r, input logic dz);
    exp_t e;
    e.q = q;
    e.r = r;
    e.dz = dz;
    return e;
  endfunction

  // Reference: truncating division on magnitudes, remainder takes dividend sign.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic        na;
    logic        nb;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) return mk(32'hFFFFFFFF, a, 1'b1);
    na = s & a[31];
    nb = s & b[31];
    ma = na ? (~a + 32'd1) : a;
    mb = nb ? (~b + 32'd1) : b;
    q = ma / mb;
    r = ma % mb;
    if (na ^ nb) q = ~q + 32'd1;
    if (na) r = ~r + 32'd1;
    return mk(q, r, 1'b0);
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s, input exp_t e);
    dividend = a;
    divisor = b;
    signed_op = s;
    start = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    dividend = $urandom;
    divisor = $urandom;
    signed_op = 1'($urandom_range(0, 1));
  endtask

  // Waits (bounded) for done; returns cycles waited, busy cycles and results.
  task automatic finish_op(output int lat, output int bcyc, output exp_t e, output exp_t got);
    lat = 0;
    bcyc = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy === 1'b1) bcyc++;
      @(negedge clk);
      lat++;
    end
    got = mk(quotient, remainder, div_by_zero);
    if (sb.size() > 0) e = sb.pop_front();
    else e = 'x;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    signed_op = 1'b0;
    dividend = '0;
    divisor = '0;
    @(negedge clk);
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b dz=%b q=%h r=%h expected all zero", busy, done, div_by_zero, quotient, remainder);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned;
    int lat;
    int bcyc;
    exp_t e;
    exp_t g;
    launch(32'd100, 32'd7, 1'b0, mk(32'd14, 32'd2, 1'b0));
    finish_op(lat, bcyc, e, g);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL unsigned_latency: got %0d expected 33", lat); end
    checks++;
    if (bcyc !== 33) begin errors++; $display("FAIL unsigned_busy_cycles: got %0d expected 33", bcyc); end
    checks++;
    if (g !== e) begin errors++; $display("FAIL unsigned_100_7: got q=%h r=%h dz=%b expected q=%h r=%h dz=%b", g.q, g.r, g.dz, e.q, e.r, e.dz); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: done=%b expected 0", done); end
  endtask

  task automatic test_signed;
    int lat;
    int bcyc;
    exp_t e;
    exp_t g;
    logic [31:0] va [3] = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9};
    logic [31:0] vn [3] = '{32'hFFFFFF9C, 32'hFFFFFF9C, 32'd100};
    exp_t ve [3];
    ve[0] = mk(32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
    ve[1] = mk(32'd14, 32'hFFFFFFFE, 1'b0);
    ve[2] = mk(32'hFFFFFFF2, 32'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      launch(vn[i], va[i], 1'b1, ve[i]);
      finish_op(lat, bcyc, e, g);
      checks++;
      if (lat !== 33 || g !== e) begin
        errors++;
        $display("FAIL signed_%0d: lat=%0d q=%h r=%h dz=%b expected lat=33 q=%h r=%h dz=%b", i, lat, g.q, g.r, g.dz, e.q, e.r, e.dz);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero;
    int lat;
    int bcyc;
    exp_t e;
    exp_t g;
    launch(32'h12345678, 32'd0, 1'b0, mk(32'hFFFFFFFF, 32'h12345678, 1'b1));
    finish_op(lat, bcyc, e, g);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL div_zero_latency: got %0d expected 1", lat); end
    checks++;
    if (g !== e) begin errors++; $display("FAIL div_zero_unsigned: got q=%h r=%h dz=%b expected q=%h r=%h dz=%b", g.q, g.r, g.dz, e.q, e.r, e.dz); end
    @(negedge clk);
    launch(32'h87654321, 32'd0, 1'b1, mk(32'hFFFFFFFF, 32'h87654321, 1'b1));
    finish_op(lat, bcyc, e, g);
    checks++;
    if (lat !== 1 || g !== e) begin
      errors++;
      $display("FAIL div_zero_signed: lat=%0d q=%h r=%h dz=%b expected lat=1 q=%h r=%h dz=%b", lat, g.q, g.r, g.dz, e.q, e.r, e.dz);
    end
    @(negedge clk);
  endtask

  task automatic test_boundaries;
    int lat;
    int bcyc;
    exp_t e;
    exp_t g;
    logic [31:0] va [3] = '{32'h80000000, 32'hFFFFFFFF, 32'd5};
    logic [31:0] vb [3] = '{32'hFFFFFFFF, 32'd1, 32'd9};
    logic        vs [3] = '{1'b1, 1'b0, 1'b0};
    exp_t ve [3];
    ve[0] = mk(32'h80000000, 32'd0, 1'b0);
    ve[1] = mk(32'hFFFFFFFF, 32'd0, 1'b0);
    ve[2] = mk(32'd0, 32'd5, 1'b0);
    for (int i = 0; i < 3; i++) begin
      launch(va[i], vb[i], vs[i], ve[i]);
      finish_op(lat, bcyc, e, g);
      checks++;
      if (lat !== 33 || g !== e) begin
        errors++;
        $display("FAIL boundary_%0d: lat=%0d q=%h r=%h dz=%b expected lat=33 q=%h r=%h dz=%b", i, lat, g.q, g.r, g.dz, e.q, e.r, e.dz);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    int lat;
    int bcyc;
    int exp_lat;
    exp_t e;
    exp_t g;
    logic [31:0] a;
    logic [31:0] b;
    logic s;
    for (int i = 0; i < 8; i++) begin
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      s = 1'(i % 3 != 0);
      exp_lat = (b == 32'd0) ? 1 : 33;
      launch(a, b, s, model(a, b, s));
      finish_op(lat, bcyc, e, g);
      checks++;
      if (lat !== exp_lat || g !== e) begin
        errors++;
        $display("FAIL random_%0d (%h/%h s=%b): lat=%0d q=%h r=%h dz=%b expected lat=%0d q=%h r=%h dz=%b", i, a, b, s, lat, g.q, g.r, g.dz, exp_lat, e.q, e.r, e.dz);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_while_busy;
    int lat;
    int bcyc;
    int extra;
    exp_t e;
    exp_t g;
    launch(32'd1000, 32'd3, 1'b0, mk(32'd333, 32'd1, 1'b0));
    repeat (9) @(negedge clk);
    dividend = 32'd50;
    divisor = 32'd5;
    signed_op = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    finish_op(lat, bcyc, e, g);
    checks++;
    if (lat + 10 !== 33 || g !== e) begin
      errors++;
      $display("FAIL start_while_busy: lat=%0d q=%h r=%h dz=%b expected lat=33 q=%h r=%h dz=%b", lat + 10, g.q, g.r, g.dz, e.q, e.r, e.dz);
    end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL ignored_start_queued: active cycles=%0d expected 0", extra); end
  endtask

  task automatic test_back_to_back;
    int lat;
    int bcyc;
    int held;
    exp_t e;
    exp_t g;
    launch(32'd200, 32'd9, 1'b0, mk(32'd22, 32'd2, 1'b0));
    finish_op(lat, bcyc, e, g);
    checks++;
    if (lat !== 33 || g !== e) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d q=%h r=%h dz=%b expected lat=33 q=%h r=%h dz=%b", lat, g.q, g.r, g.dz, e.q, e.r, e.dz);
    end
    // Still in the done cycle: this start must be accepted.
    launch(32'd77, 32'hFFFFFFFB, 1'b1, mk(32'hFFFFFFF1, 32'd2, 1'b0));
    held = 1;
    repeat (16) begin
      if (quotient !== 32'd22 || remainder !== 32'd2 || done !== 1'b0) held = 0;
      @(negedge clk);
    end
    checks++;
    if (held !== 1) begin errors++; $display("FAIL b2b_hold: held=%0d expected 1", held); end
    finish_op(lat, bcyc, e, g);
    checks++;
    if (lat + 16 !== 33 || g !== e) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d q=%h r=%h dz=%b expected lat=33 q=%h r=%h dz=%b", lat + 16, g.q, g.r, g.dz, e.q, e.r, e.dz);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    int lat;
    int bcyc;
    int extra;
    exp_t e;
    exp_t g;
    dividend = 32'd123456;
    divisor = 32'd789;
    signed_op = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || quotient !== 32'd0 || remainder !== 32'd0) begin
      errors++;
      $display("FAIL async_reset_clear: busy=%b done=%b dz=%b q=%h r=%h expected all zero", busy, done, div_by_zero, quotient, remainder);
    end
    @(negedge clk);
    reset = 1'b0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) extra++;
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL async_reset_abort: active cycles=%0d expected 0", extra); end
    launch(32'd123456, 32'd789, 1'b0, mk(32'd156, 32'd372, 1'b0));
    finish_op(lat, bcyc, e, g);
    checks++;
    if (lat !== 33 || g !== e) begin
      errors++;
      $display("FAIL after_reset_op: lat=%0d q=%h r=%h dz=%b expected lat=33 q=%h r=%h dz=%b", lat, g.q, g.r, g.dz, e.q, e.r, e.dz);
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    start = 1'b0;
    signed_op = 1'b0;
    dividend = '0;
    divisor = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_boundaries();
    test_random();
    test_start_while_busy();
    test_back_to_back();
    test_async_reset();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
